// File: rtl/dma_pkg.sv
// Shared DMA types and constants.
// FSM states, error codes, 4 KB page size and AXI encodings.
package dma_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_CALC,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FINISH,
    S_ERR
  } sched_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RRESP    = 2'd2,
    ERR_BRESP    = 2'd3
  } err_code_t;

  localparam int AXI_4KB = 4096;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst beat count: min(remaining, max, src/dst 4 KB room).
// In: remaining, src/dst low 12 bits, size, inc modes. Out: beats.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int MAX_BURST_BEATS = 16,
  parameter int CNT_W           = 16
) (
  input  logic [CNT_W-1:0] remaining,
  input  logic [11:0]      src_lo,
  input  logic [11:0]      dst_lo,
  input  logic [1:0]       size,
  input  logic             src_inc,
  input  logic             dst_inc,
  output logic [12:0]      beats
);

  logic [12:0] lim_src;
  logic [12:0] lim_dst;

  always_comb begin
    lim_src = (13'(AXI_4KB) - {1'b0, src_lo}) >> size;
    lim_dst = (13'(AXI_4KB) - {1'b0, dst_lo}) >> size;
    beats   = 13'(MAX_BURST_BEATS);
    if (32'(remaining) < 32'(beats))
      beats = 13'(remaining);
    if (src_inc && lim_src < beats)
      beats = lim_src;
    if (dst_inc && lim_dst < beats)
      beats = lim_dst;
  end

endmodule

// File: rtl/dma_burst_scheduler.sv
// Single-channel DMA burst sequencer: splits a descriptor into
// read/write burst pairs; reports busy/done/err to the register block.
module dma_burst_scheduler
  import dma_pkg::*;
#(
  parameter int MAX_BURST_BEATS = 16,
  parameter int CNT_W           = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      cfg_src_addr,
  input  logic [31:0]      cfg_dst_addr,
  input  logic [CNT_W-1:0] cfg_num_beats,
  input  logic [1:0]       cfg_burst_size,
  input  logic             cfg_src_inc,
  input  logic             cfg_dst_inc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] beats_done,
  output logic             start_read_burst,
  output logic             start_write_burst,
  output logic [31:0]      read_addr,
  output logic [31:0]      write_addr,
  output logic [7:0]       burst_len,
  output logic [1:0]       burst_size,
  output logic             src_inc,
  output logic             dst_inc,
  input  logic             read_burst_done,
  input  logic             write_burst_done,
  input  logic [1:0]       write_resp,
  input  logic             axi_error
);

  sched_state_t     state;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] bdone_q;
  logic [1:0]       size_q;
  logic             sinc_q;
  logic             dinc_q;
  logic [12:0]      beats_q;
  logic [7:0]       len_q;
  logic             err_q;
  err_code_t        code_q;
  logic             abort_q;

  logic [12:0]      calc_beats;
  logic [12:0]      len13;
  logic [1:0]       amask;
  logic             misalign;

  dma_burst_calc #(
    .MAX_BURST_BEATS(MAX_BURST_BEATS),
    .CNT_W          (CNT_W)
  ) u_calc (
    .remaining(rem_q),
    .src_lo   (src_q[11:0]),
    .dst_lo   (dst_q[11:0]),
    .size     (size_q),
    .src_inc  (sinc_q),
    .dst_inc  (dinc_q),
    .beats    (calc_beats)
  );

  assign len13 = calc_beats - 13'd1;

  always_comb begin
    unique case (size_q)
      2'd0:    amask = 2'b00;
      2'd1:    amask = 2'b01;
      default: amask = 2'b11;
    endcase
    misalign = (size_q == 2'd3) ||
               (|((src_q[1:0] | dst_q[1:0]) & amask));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      bdone_q <= '0;
      size_q  <= '0;
      sinc_q  <= 1'b0;
      dinc_q  <= 1'b0;
      beats_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      abort_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          src_q   <= cfg_src_addr;
          dst_q   <= cfg_dst_addr;
          rem_q   <= cfg_num_beats;
          size_q  <= cfg_burst_size;
          sinc_q  <= cfg_src_inc;
          dinc_q  <= cfg_dst_inc;
          bdone_q <= '0;
          err_q   <= 1'b0;
          code_q  <= ERR_NONE;
          abort_q <= 1'b0;
          state   <= S_CHECK;
        end
        S_CHECK: begin
          if (misalign) begin
            code_q <= ERR_MISALIGN;
            state  <= S_ERR;
          end else if (rem_q == '0) begin
            state <= S_FINISH;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          beats_q <= calc_beats;
          len_q   <= len13[7:0];
          if (abort) begin
            abort_q <= 1'b1;
            state   <= S_FINISH;
          end else begin
            state <= S_RD_REQ;
          end
        end
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT: if (read_burst_done) begin
          if (axi_error) begin
            code_q <= ERR_RRESP;
            state  <= S_ERR;
          end else begin
            state <= S_WR_REQ;
          end
        end
        S_WR_REQ: state <= S_WR_WAIT;
        S_WR_WAIT: if (write_burst_done) begin
          if (write_resp != RESP_OKAY) begin
            code_q <= ERR_BRESP;
            state  <= S_ERR;
          end else begin
            bdone_q <= bdone_q + CNT_W'(beats_q);
            rem_q   <= rem_q - CNT_W'(beats_q);
            if (sinc_q)
              src_q <= src_q + (32'(beats_q) << size_q);
            if (dinc_q)
              dst_q <= dst_q + (32'(beats_q) << size_q);
            state <= S_CHECK;
          end
        end
        S_FINISH: state <= S_IDLE;
        S_ERR: begin
          err_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy              = (state != S_IDLE);
  assign done              = (state == S_FINISH) && !abort_q;
  assign err               = err_q;
  assign err_code          = code_q;
  assign beats_done        = bdone_q;
  assign start_read_burst  = (state == S_RD_REQ);
  assign start_write_burst = (state == S_WR_REQ);
  assign read_addr         = src_q;
  assign write_addr        = dst_q;
  assign burst_len         = len_q;
  assign burst_size        = size_q;
  assign src_inc           = sinc_q;
  assign dst_inc           = dinc_q;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
// Directed bench for dma_burst_scheduler with a simple
// AXI master-interface responder and burst logging.
module tb_dma_burst_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_src_addr = '0;
  logic [31:0] cfg_dst_addr = '0;
  logic [15:0] cfg_num_beats = '0;
  logic [1:0]  cfg_burst_size = '0;
  logic        cfg_src_inc = 1'b0;
  logic        cfg_dst_inc = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [15:0] beats_done;
  logic        start_read_burst, start_write_burst;
  logic [31:0] read_addr, write_addr;
  logic [7:0]  burst_len;
  logic [1:0]  burst_size;
  logic        src_inc, dst_inc;
  logic        read_burst_done = 1'b0;
  logic        write_burst_done = 1'b0;
  logic [1:0]  write_resp = 2'b00;
  logic        axi_error = 1'b0;

  dma_burst_scheduler #(
    .MAX_BURST_BEATS(16),
    .CNT_W          (16)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .start            (start),
    .abort            (abort),
    .cfg_src_addr     (cfg_src_addr),
    .cfg_dst_addr     (cfg_dst_addr),
    .cfg_num_beats    (cfg_num_beats),
    .cfg_burst_size   (cfg_burst_size),
    .cfg_src_inc      (cfg_src_inc),
    .cfg_dst_inc      (cfg_dst_inc),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .err_code         (err_code),
    .beats_done       (beats_done),
    .start_read_burst (start_read_burst),
    .start_write_burst(start_write_burst),
    .read_addr        (read_addr),
    .write_addr       (write_addr),
    .burst_len        (burst_len),
    .burst_size       (burst_size),
    .src_inc          (src_inc),
    .dst_inc          (dst_inc),
    .read_burst_done  (read_burst_done),
    .write_burst_done (write_burst_done),
    .write_resp       (write_resp),
    .axi_error        (axi_error)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int rd_n, wr_n, done_cnt;
  int rd_dly, wr_dly;
  int rd_err_at, wr_err_at;
  int start_cyc, done_cyc;
  logic [31:0] rd_addr [8];
  logic [7:0]  rd_len  [8];
  logic [31:0] wr_addr [8];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder: completes each burst two cycles after its request.
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      read_burst_done  = 1'b0;
      write_burst_done = 1'b0;
      axi_error        = 1'b0;
      write_resp       = 2'b00;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_dly > 0) begin
        rd_dly--;
        if (rd_dly == 0) begin
          read_burst_done = 1'b1;
          axi_error = (rd_n - 1 == rd_err_at);
        end
      end
      if (wr_dly > 0) begin
        wr_dly--;
        if (wr_dly == 0) begin
          write_burst_done = 1'b1;
          write_resp = (wr_n - 1 == wr_err_at) ? 2'b10 : 2'b00;
        end
      end
      if (start_read_burst) begin
        if (rd_n < 8) begin
          rd_addr[rd_n] = read_addr;
          rd_len[rd_n]  = burst_len;
        end
        rd_n++;
        rd_dly = 2;
      end
      if (start_write_burst) begin
        if (wr_n < 8) wr_addr[wr_n] = write_addr;
        wr_n++;
        wr_dly = 2;
      end
    end
  end

  task automatic launch(input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] nb, input logic [1:0] sz,
                        input int rerr, input int werr);
    @(negedge aclk);
    rd_n = 0; wr_n = 0; done_cnt = 0;
    rd_err_at = rerr; wr_err_at = werr;
    cfg_src_addr = s; cfg_dst_addr = d;
    cfg_num_beats = nb; cfg_burst_size = sz;
    cfg_src_inc = 1'b1; cfg_dst_inc = 1'b1;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge aclk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rd_n = 0; wr_n = 0; done_cnt = 0;
    rd_dly = 0; wr_dly = 0;
    rd_err_at = -1; wr_err_at = -1;
    start_cyc = 0; done_cyc = 0;
    repeat (3) @(negedge aclk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {busy, done, err, err_code, start_read_burst,
                     start_write_burst, burst_size, src_inc, dst_inc,
                     burst_len}, 32'd0);
    chk("rst_raddr", read_addr, 32'd0);
    chk("rst_bdone", {16'd0, beats_done}, 32'd0);
    aresetn = 1'b1;

    // 40 beats: 16 + 16 + 8
    launch(32'h1000, 32'h2000, 16'd40, 2'd2, -1, -1);
    wait_idle("t1_idle");
    chk("t1_nrd", rd_n, 3);
    chk("t1_len0", {24'd0, rd_len[0]}, 32'd15);
    chk("t1_len1", {24'd0, rd_len[1]}, 32'd15);
    chk("t1_len2", {24'd0, rd_len[2]}, 32'd7);
    chk("t1_raddr2", rd_addr[2], 32'h1080);
    chk("t1_waddr1", wr_addr[1], 32'h2040);
    chk("t1_done", done_cnt, 1);
    chk("t1_bdone", {16'd0, beats_done}, 32'd40);
    chk("t1_err", {31'd0, err}, 32'd0);

    // 4 KB boundary split
    launch(32'h1FF0, 32'h3000, 16'd8, 2'd2, -1, -1);
    wait_idle("t2_idle");
    chk("t2_nrd", rd_n, 2);
    chk("t2_len0", {24'd0, rd_len[0]}, 32'd3);
    chk("t2_raddr1", rd_addr[1], 32'h2000);
    chk("t2_len1", {24'd0, rd_len[1]}, 32'd3);
    chk("t2_waddr1", wr_addr[1], 32'h3010);
    chk("t2_bdone", {16'd0, beats_done}, 32'd8);

    // zero-length transfer
    launch(32'h1000, 32'h2000, 16'd0, 2'd2, -1, -1);
    wait_idle("t3_idle");
    chk("t3_nrd", rd_n, 0);
    chk("t3_done", done_cnt, 1);
    chk("t3_lat", (done_cyc - start_cyc <= 3) ? 1 : 0, 1);

    // misaligned source
    launch(32'h1002, 32'h2000, 16'd4, 2'd2, -1, -1);
    wait_idle("t4_idle");
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_code", {30'd0, err_code}, 32'd1);
    chk("t4_axi", rd_n + wr_n, 0);
    chk("t4_done", done_cnt, 0);

    // bresp error on second burst
    launch(32'h1000, 32'h2000, 16'd32, 2'd2, -1, 1);
    wait_idle("t5_idle");
    chk("t5_err", {31'd0, err}, 32'd1);
    chk("t5_code", {30'd0, err_code}, 32'd3);
    chk("t5_bdone", {16'd0, beats_done}, 32'd16);
    chk("t5_done", done_cnt, 0);

    // abort during first burst
    launch(32'h1000, 32'h2000, 16'd48, 2'd2, -1, -1);
    for (int i = 0; i < 50 && rd_n == 0; i++) @(negedge aclk);
    abort = 1'b1;
    wait_idle("t6_idle");
    abort = 1'b0;
    chk("t6_nrd", rd_n, 1);
    chk("t6_done", done_cnt, 0);
    chk("t6_err", {31'd0, err}, 32'd0);
    chk("t6_bdone", {16'd0, beats_done}, 32'd16);

    // read error on first burst, byte beats
    launch(32'h0001, 32'h0003, 16'd5, 2'd0, 0, -1);
    wait_idle("t7_idle");
    chk("t7_len0", {24'd0, rd_len[0]}, 32'd4);
    chk("t7_code", {30'd0, err_code}, 32'd2);
    chk("t7_nwr", wr_n, 0);
    chk("t7_bdone", {16'd0, beats_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
